// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//
// Contents:
//   state_t    - controller states (IDLE, CALC, DONE)
//   cnt_width  - width of the iteration counter for a given operand width;
//                sized to hold the value WIDTH so the counter never wraps
//                early for any WIDTH in 2..32.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
//
// Ports:
//   rem_in   [WIDTH-1:0]  in   current partial remainder R (always < divisor)
//   q_msb                 in   next dividend bit shifted into the remainder
//   divisor  [WIDTH-1:0]  in   divisor (non-zero while iterating)
//   rem_out  [WIDTH-1:0]  out  next partial remainder
//   q_bit                 out  quotient bit produced by this iteration
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    // {R, q_msb} is below 2*divisor because R < divisor, so when the trial
    // subtraction succeeds the result fits in WIDTH bits, and when it borrows
    // the wrapped WIDTH+1-bit result always has its top bit set. The top bit
    // is therefore exactly the borrow.
    assign trial   = {rem_in, q_msb} - {1'b0, divisor};
    assign q_bit   = ~trial[WIDTH];
    assign rem_out = q_bit ? trial[WIDTH-1:0] : {rem_in[WIDTH-2:0], q_msb};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/done handshake.
// One quotient bit is produced per clock, so a non-zero divide takes WIDTH
// cycles; a zero divisor completes in a single cycle with a flag.
//
// Ports:
//   clk                      in   rising-edge clock
//   rst_n                    in   asynchronous active-low reset
//   start                    in   request, honoured only while not busy
//   dividend    [WIDTH-1:0]  in   unsigned dividend, captured with start
//   divisor     [WIDTH-1:0]  in   unsigned divisor, captured with start
//   busy                     out  operation in progress
//   done                     out  one-cycle pulse, results valid
//   quotient    [WIDTH-1:0]  out  registered quotient
//   remainder   [WIDTH-1:0]  out  registered remainder
//   div_by_zero              out  registered, set with done for divisor 0
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] rem_acc;   // partial remainder R
    logic [WIDTH-1:0] shq;       // dividend bits shifting out, quotient bits in
    logic [WIDTH-1:0] dvs;       // divisor captured at start
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] shq_next;
    logic             last_iter;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_acc),
        .q_msb   (shq[WIDTH-1]),
        .divisor (dvs),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    assign shq_next  = {shq[WIDTH-2:0], q_bit};
    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rem_acc     <= '0;
            shq         <= '0;
            dvs         <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                // DONE behaves like IDLE for a new request so results can be
                // issued back-to-back without an idle cycle in between.
                IDLE, DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        if (divisor != '0) begin
                            rem_acc     <= '0;
                            shq         <= dividend;
                            dvs         <= divisor;
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            state       <= CALC;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                CALC: begin
                    rem_acc <= rem_next;
                    shq     <= shq_next;
                    cnt     <= cnt + CW'(1);
                    if (last_iter) begin
                        quotient  <= shq_next;
                        remainder <= rem_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=16 plus a WIDTH=8 operand sweep
// against a reference division model.
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        s16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16, done16, z16;
    logic [15:0] q16, r16;

    logic        s8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, z8;
    logic [7:0]  q8, r8;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (done16) done_cnt++;

    seq_divider #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .dividend(a16), .divisor(b16),
        .busy(busy16), .done(done16), .quotient(q16), .remainder(r16),
        .div_by_zero(z16)
    );

    seq_divider #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .dividend(a8), .divisor(b8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8),
        .div_by_zero(z8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits from just after the start edge until done, counting edges.
    task automatic wait16(output int k);
        k = 0;
        while (!done16 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic ez, input int ek);
        int k;
        @(negedge clk);
        a16 = a; b16 = b; s16 = 1'b1;
        @(posedge clk); #1;
        s16 = 1'b0;
        a16 = 16'h5A5A; b16 = 16'h0003;   // operand changes must not matter
        if (b != 16'd0) begin
            chk({tag, "_busy_calc"}, busy16, 1'b1);
            chk({tag, "_done_calc"}, done16, 1'b0);
        end
        wait16(k);
        chk({tag, "_done"}, done16, 1'b1);
        chk({tag, "_busy_at_done"}, busy16, 1'b0);
        chk({tag, "_q"}, q16, eq);
        chk({tag, "_r"}, r16, er);
        chk({tag, "_dbz"}, z16, ez);
        chk({tag, "_latency"}, k, ek);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done16, 1'b0);
    endtask

    initial begin
        int k;
        int d0;
        logic [7:0] ea, eb, eq8, er8;
        logic       ez8;

        // Reset state
        #2;
        chk("rst_busy", busy16, 1'b0);
        chk("rst_done", done16, 1'b0);
        chk("rst_q", q16, 16'h0);
        chk("rst_r", r16, 16'h0);
        chk("rst_dbz", z16, 1'b0);
        chk("rst8_q", q8, 8'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic divisions
        run16("d100_7",    16'd100,   16'd7,     16'd14,   16'd2, 1'b0, 16);
        run16("dffff_1",   16'hFFFF,  16'h0001,  16'hFFFF, 16'h0, 1'b0, 16);
        run16("d3_10",     16'd3,     16'd10,    16'd0,    16'd3, 1'b0, 16);
        run16("d8000_8000",16'h8000,  16'h8000,  16'd1,    16'd0, 1'b0, 16);
        run16("d5_0",      16'd5,     16'd0,     16'hFFFF, 16'd5, 1'b1, 0);
        run16("d9_2",      16'd9,     16'd2,     16'd4,    16'd1, 1'b0, 16);

        // Start during CALC is ignored; start in DONE is accepted
        d0 = done_cnt;
        @(negedge clk);
        a16 = 16'd100; b16 = 16'd7; s16 = 1'b1;
        @(posedge clk); #1;
        s16 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        a16 = 16'd50; b16 = 16'd3; s16 = 1'b1;
        @(negedge clk);
        s16 = 1'b0;
        @(posedge clk); #1;
        wait16(k);
        chk("ign_done", done16, 1'b1);
        chk("ign_q", q16, 16'd14);
        chk("ign_r", r16, 16'd2);
        chk("ign_single_done", done_cnt, d0);
        a16 = 16'd50; b16 = 16'd3; s16 = 1'b1;   // held high through the DONE cycle
        @(posedge clk); #1;
        s16 = 1'b0;
        chk("b2b_busy", busy16, 1'b1);
        chk("b2b_done_low", done16, 1'b0);
        wait16(k);
        chk("b2b_done", done16, 1'b1);
        chk("b2b_q", q16, 16'd16);
        chk("b2b_r", r16, 16'd2);
        chk("b2b_latency", k, 16);

        // Reset mid-CALC
        @(negedge clk);
        a16 = 16'd1000; b16 = 16'd7; s16 = 1'b1;
        @(posedge clk); #1;
        s16 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy16, 1'b0);
        chk("mid_rst_done", done16, 1'b0);
        chk("mid_rst_q", q16, 16'h0);
        chk("mid_rst_r", r16, 16'h0);
        chk("mid_rst_dbz", z16, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done_cnt, d0);
        run16("d1000_33", 16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 16);

        // WIDTH=8 sweep against a/b and a%b
        for (int i = 0; i < 1000; i++) begin
            ea = 8'($urandom_range(0, 255));
            if (i % 10 == 0)
                eb = 8'd0;
            else if (i % 10 == 1 && ea != 8'hFF)
                eb = 8'($urandom_range(int'(ea) + 1, 255));
            else
                eb = 8'($urandom_range(1, 255));
            if (eb == 8'd0) begin
                eq8 = 8'hFF; er8 = ea; ez8 = 1'b1;
            end else begin
                eq8 = ea / eb; er8 = ea % eb; ez8 = 1'b0;
            end
            @(negedge clk);
            a8 = ea; b8 = eb; s8 = 1'b1;
            @(posedge clk); #1;
            s8 = 1'b0;
            k = 0;
            while (!done8 && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
            chk("w8_done", done8, 1'b1);
            chk("w8_q", q8, eq8);
            chk("w8_r", r8, er8);
            chk("w8_dbz", z8, ez8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
